uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 rx_data_i  input  8  byte from UART receiver.
REQ-005 rx_valid_i  input  1  one-cycle strobe; rx_data_i and rx_frame_err_i are valid this cycle.
REQ-006 rx_frame_err_i  input  1  stop-bit error flag for the byte being strobed.
REQ-007 ren  input  1  bus read enable.
REQ-008 we  input  1  bus write enable.
REQ-009 addr  input  8  byte address: 0x00 DATA, 0x04 STATUS, 0x08 CTRL.
REQ-010 wdata  input  32  bus write data.
REQ-011 rdata  output  32  bus read data.
REQ-012 intr_rx_o  output  1  level interrupt to CPU.

Function
REQ-013 Storage SHALL be DEPTH x 9 bits: {frame_err, byte}; count width is clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-014 Push SHALL occur on a rising edge with rx_valid_i=1 and CTRL.en=1; rx_valid_i SHALL be ignored when en=0.
REQ-015 rdata SHALL be combinational from addr when ren=1, and 0 when ren=0 or addr is unmapped.
REQ-016 DATA read SHALL return {22'b0, empty, frame_err, byte} of the head entry; with empty=1 the lower 9 bits SHALL be 0.
REQ-017 Pop SHALL occur on the rising edge where ren=1, addr=0x00 and the FIFO is non-empty; a DATA read while empty SHALL not change the pointers.
REQ-018 STATUS SHALL read {16'b0, count[7:0], 4'b0, ovf, thr_hit, full, empty}.
REQ-019 CTRL SHALL read {23'b0, thr[7:0], en}; a write with we=1, addr=0x08 SHALL load en=wdata[0] and thr=wdata[8:1].
REQ-020 Writing wdata[31]=1 to CTRL SHALL flush the FIFO next edge (pointers and count to 0), overriding any push or pop in that cycle.
REQ-021 A STATUS write with wdata[3]=1 SHALL clear ovf; the other STATUS bits SHALL be read-only.
REQ-022 Push while full with no pop in the same cycle SHALL drop the byte, leave storage unchanged and set ovf sticky.
REQ-023 Push and pop in the same cycle when full SHALL both take effect; count unchanged, ovf not set.
REQ-024 Push and pop in the same cycle when empty SHALL perform the push only; count becomes 1.
REQ-025 Push and pop in the same cycle otherwise SHALL both take effect, count unchanged.
REQ-026 Effective threshold SHALL be max(thr,1), clamped to DEPTH; thr_hit = (count >= effective threshold).
REQ-027 intr_rx_o SHALL be registered: intr_rx_o = en & (thr_hit | ovf), updated one edge after the causing state change.
REQ-028 Bus writes with unmapped addr SHALL have no effect; we and ren both high SHALL perform both actions.

Reset
REQ-029 On rst_ni=0 SHALL clear immediately: pointers, count, ovf, en (0), thr (1), intr_rx_o (0); storage contents need not be reset.
REQ-030 Reset asserted mid-push or mid-pop SHALL discard the operation; after release, STATUS SHALL read 0x00000001.

Verification
REQ-031 Reset release, read STATUS -> 0x00000001; read CTRL -> 0x00000002; intr_rx_o=0.
REQ-032 CTRL=0x09 (en=1, thr=4), push 0x41,0x42,0x43 -> count=3, intr_rx_o=0; push 0x44 -> intr_rx_o=1 one edge later; four DATA reads return 0x41..0x44 in order, then 0x200 (empty).
REQ-033 en=1, push DEPTH bytes -> full=1; push 0xAA -> ovf=1, 0xAA absent, intr_rx_o=1; write STATUS 0x8 -> ovf=0.
REQ-034 Full FIFO, push 0x55 and DATA read in the same cycle -> read returns the head byte, count stays DEPTH, ovf=0, last entry 0x55.
REQ-035 Push 0x10 with rx_frame_err_i=1 -> DATA read returns 0x110; CTRL write 0x80000001 with 3 entries -> STATUS empty=1, count=0.
REQ-036 en=0, strobe rx_valid_i with 0x77 -> count stays 0; rst_ni low during a push with 2 entries -> STATUS 0x00000001 after release.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO between a UART receiver and a CPU register bus.
//
// Bytes strobed in by the receiver (with their stop-bit error flag) are
// queued while CTRL.en is set. The CPU pops them through the DATA register.
// A level interrupt fires when the fill level reaches a programmable
// threshold, or when a byte was dropped because the FIFO was full.
//
// Ports
//   clk_i           clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   rx_data_i       received byte
//   rx_valid_i      one-cycle strobe qualifying rx_data_i / rx_frame_err_i
//   rx_frame_err_i  stop-bit error for the strobed byte
//   ren, we         bus read / write enables (both may be high together)
//   addr            byte address: 0x00 DATA, 0x04 STATUS, 0x08 CTRL
//   wdata           bus write data
//   rdata           combinational bus read data (0 when idle or unmapped)
//   intr_rx_o       registered level interrupt
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_frame_err_i,
    input  logic        ren,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intr_rx_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;

    // Storage entry is {frame_err, byte}
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          en;
    logic [7:0]    thr;

    logic          empty, full;
    logic [9:0]    count_x;
    logic [9:0]    thr_eff;
    logic          thr_hit;
    logic [8:0]    head;

    logic          ctrl_wr, status_wr, flush;
    logic          push_req, push, pop;
    logic          unused_wdata;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign count_x = 10'(count);
    assign head    = mem[rptr];

    // A threshold of 0 behaves as 1, and anything past DEPTH could never be
    // reached, so it is clamped to DEPTH.
    always_comb begin
        thr_eff = 10'(thr);
        if (thr == 8'd0)
            thr_eff = 10'd1;
        else if (10'(thr) > 10'(DEPTH))
            thr_eff = 10'(DEPTH);
    end

    assign thr_hit = (count_x >= thr_eff);

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign status_wr = we && (addr == ADDR_STATUS);
    assign flush     = ctrl_wr && wdata[31];

    assign push_req = rx_valid_i && en;
    assign pop      = ren && (addr == ADDR_DATA) && !empty;
    // When full, a push only lands if a pop frees the slot in the same edge.
    assign push     = push_req && (!full || pop);

    // Only the CTRL and STATUS fields are decoded from the write data.
    assign unused_wdata = ^wdata[30:9];

    // Bus read mux
    always_comb begin
        rdata = 32'd0;
        if (ren) begin
            case (addr)
                ADDR_DATA:   rdata = {22'd0, empty, (empty ? 9'd0 : head)};
                ADDR_STATUS: rdata = {16'd0, count_x[7:0], 4'd0, ovf, thr_hit, full, empty};
                ADDR_CTRL:   rdata = {23'd0, thr, en};
                default:     rdata = 32'd0;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push && !flush)
            mem[wptr] <= {rx_frame_err_i, rx_data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            en        <= 1'b0;
            thr       <= 8'd1;
            intr_rx_o <= 1'b0;
        end else begin
            // Interrupt is derived from the current registered state, so it
            // follows any state change by one edge.
            intr_rx_o <= en && (thr_hit || ovf);

            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // A fresh overflow wins over a clear in the same cycle so the
            // event is never lost.
            if (push_req && full && !pop && !flush)
                ovf <= 1'b1;
            else if (status_wr && wdata[3])
                ovf <= 1'b0;

            if (ctrl_wr) begin
                en  <= wdata[0];
                thr <= wdata[8:1];
            end
        end
    end

endmodule
